// File: rtl/alu_result_history_pkg.sv
// Shared parameters for the ALU result history stage: default widths, derived
// pointer/count widths and the reset value of the key edge-detector registers.
package alu_result_history_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Resetting the "previous level" high means a key held through reset
  // produces no pulse until it is released and pressed again.
  localparam logic EDGE_RST = 1'b1;

endpackage : alu_result_history_pkg

// File: rtl/alu_result_history_edge.sv
// Rising-edge detector for a debounced key level; emits a one-cycle pulse
// that is combinational from the level and the registered previous level.
module rising_edge_detect
  import alu_result_history_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic r_level_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs as they were just before the clock edge.
  always_ff @(posedge clock) begin
    if (reset) r_level_q <= EDGE_RST;
    else       r_level_q <= level;
  end

  assign pulse = level & ~r_level_q;

endmodule : rising_edge_detect

// File: rtl/alu_result_history.sv
// Captures the ALU result on a key press into `latest` and a circular history,
// and lets a second key page through the valid history entries for display.
module alu_result_history
  import alu_result_history_pkg::*;
#(
  parameter int P_DATA_W = DATA_W,
  parameter int P_DEPTH  = DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          capture,
  input  logic                          scroll,
  input  logic                          hist_clear,
  input  logic [P_DATA_W-1:0]           alu_result,
  output logic [P_DATA_W-1:0]           latest,
  output logic [P_DATA_W-1:0]           view_data,
  output logic [$clog2(P_DEPTH)-1:0]    view_index,
  output logic [$clog2(P_DEPTH):0]      count,
  output logic                          full
);

  localparam int L_PTR_W = $clog2(P_DEPTH);
  localparam int L_CNT_W = L_PTR_W + 1;

  logic [P_DATA_W-1:0] r_mem [P_DEPTH];
  logic [P_DATA_W-1:0] r_latest;
  logic [L_PTR_W-1:0]  r_wr_ptr;
  logic [L_PTR_W-1:0]  r_view_index;
  logic [L_CNT_W-1:0]  r_count;

  logic                w_cap_pulse;
  logic                w_scr_pulse;
  logic                w_full;
  logic [L_CNT_W-1:0]  w_next_view;
  logic [L_PTR_W-1:0]  w_rd_ptr;

  rising_edge_detect u_cap_edge (
    .clock (clock),
    .reset (reset),
    .level (capture),
    .pulse (w_cap_pulse)
  );

  rising_edge_detect u_scr_edge (
    .clock (clock),
    .reset (reset),
    .level (scroll),
    .pulse (w_scr_pulse)
  );

  assign w_full      = (r_count == L_CNT_W'(P_DEPTH));
  assign w_next_view = {1'b0, r_view_index} + L_CNT_W'(1);
  // Newest entry sits just behind the write pointer; older ones further back.
  assign w_rd_ptr    = r_wr_ptr - L_PTR_W'(1) - r_view_index;

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the history array is reset explicitly so every entry reads 0
      // after reset; this forces flops rather than a RAM macro for the store.
      for (int i = 0; i < P_DEPTH; i++) r_mem[i] <= '0;
      r_latest     <= '0;
      r_wr_ptr     <= '0;
      r_view_index <= '0;
      r_count      <= '0;
    end else if (hist_clear) begin
      r_wr_ptr     <= '0;
      r_view_index <= '0;
      r_count      <= '0;
    end else if (w_cap_pulse) begin
      r_mem[r_wr_ptr] <= alu_result;
      r_wr_ptr        <= r_wr_ptr + L_PTR_W'(1);
      r_latest        <= alu_result;
      r_view_index    <= '0;
      if (!w_full) r_count <= r_count + L_CNT_W'(1);
    end else if (w_scr_pulse && (r_count != '0)) begin
      if (w_next_view == r_count) r_view_index <= '0;
      else                        r_view_index <= w_next_view[L_PTR_W-1:0];
    end
  end

  assign latest     = r_latest;
  assign view_index = r_view_index;
  assign count      = r_count;
  assign full       = w_full;
  assign view_data  = (r_count == '0) ? '0 : r_mem[w_rd_ptr];

endmodule : alu_result_history

// File: doc/alu_result_history.md
Name: alu_result_history

Overview:
- Stage directly downstream of the 8-bit lab ALU (function-select mux output).
- Captures the ALU result on a key press and holds the most recent result as a register (`latest`). `latest` drives LEDR and feeds back as an ALU operand.
- Keeps a circular history of the last DEPTH results; a scroll key pages through them for the HEX display encoders.

Parameters:
- DATA_W, 8, width of the ALU result and of each history entry.
- DEPTH, 4, number of history entries; power of two.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- capture  in  1  active-high level from the debounced, inverted KEY; its rising edge captures the result.
- scroll  in  1  active-high level from the inverted KEY; its rising edge advances the view.
- hist_clear  in  1  synchronous clear of the history (level, not edge).
- alu_result  in  DATA_W  ALU output to be captured.
- latest  out  DATA_W  most recently captured result.
- view_data  out  DATA_W  history entry currently selected for display.
- view_index  out  log2(DEPTH)  age of the displayed entry; 0 is the newest.
- count  out  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
- full  out  1  high when count == DEPTH.

Behaviour:
- Reset (synchronous, highest priority):
  - latest, view_index, count, write pointer and all history entries go to 0; full goes to 0.
  - Edge-detector history registers reset to 1. A key held through reset therefore produces no capture/scroll until it is released and pressed again.
- Edge detection:
  - cap_pulse = capture & ~capture_q; scr_pulse = scroll & ~scroll_q.
  - capture_q and scroll_q are registered every cycle. A pulse is acted on at the same clock edge.
  - Holding a key high gives exactly one pulse.
- Priority at each edge: reset > hist_clear > cap_pulse > scr_pulse.
- cap_pulse:
  - mem[wr_ptr] <= alu_result; wr_ptr <= wr_ptr+1 mod DEPTH.
  - count <= min(count+1, DEPTH); latest <= alu_result; view_index <= 0.
  - Latency: latest and view_data show the new value one clock after the first cycle capture is sampled high.
- Capture while full: the oldest entry is overwritten, count stays DEPTH, full stays 1 (wrap-around).
- scr_pulse:
  - If count == 0: no change.
  - Otherwise view_index <= (view_index+1 == count) ? 0 : view_index+1, i.e. it wraps within the valid entries only.
- Simultaneous cap_pulse and scr_pulse: the capture is performed and view_index = 0; the scroll is dropped.
- hist_clear:
  - count, wr_ptr and view_index go to 0. Memory contents are don't-care afterwards.
  - latest is retained, so the ALU feedback operand is undisturbed.
  - A capture in the same cycle as hist_clear is dropped.
- view_data (combinational from registers):
  - count == 0: view_data = 0.
  - Otherwise view_data = mem[(wr_ptr-1-view_index) mod DEPTH].
- full = (count == DEPTH).
- No arithmetic on the data path; alu_result is stored unmodified at the full DATA_W width.

Decomposition:
- Shared package holds:
  - DATA_W and DEPTH defaults.
  - PTR_W = log2(DEPTH) and CNT_W = PTR_W+1.
  - The reset value of the edge-detector registers (1).
- One natural sub-module, rising_edge_detect:
  - Ports: clock, reset, level in, pulse out; reset state 1.
  - Instantiated twice, for capture and scroll.

Test Plan:
- Reset, then capture with alu_result=8'h3C -> next cycle latest=8'h3C, count=1, view_data=8'h3C, view_index=0, full=0.
- Hold capture high for 10 cycles with alu_result changing each cycle -> exactly one capture of the first-cycle value, count=1.
- Capture 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 -> count=4, full=1. Scrolling shows 05, 04, 03, 02 and wraps back to 05 (8'h01 was overwritten).
- After 2 captures (8'hA0, 8'hB0), scroll three times -> view_index goes 1, 0, 1 and view_data goes B0→A0, B0, A0. With count=0, scroll leaves view_index=0 and view_data=0.
- Capture and scroll rising on the same cycle with alu_result=8'h7F -> latest=8'h7F, view_index=0, count incremented.
- With latest=8'h55 and count=3, assert hist_clear together with capture -> count=0, view_data=0, latest stays 8'h55. Separately, capture held high across reset release -> no capture until it goes low and high again.
